// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mm_pkg
// Purpose  : Shared types and constants for the UART matrix-multiplication
//            receive path: frame parser state encoding, error codes and
//            operand-memory select values.
// Revision : 1.0 - initial release
// ============================================================================
package mm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV_A = 3'd1,
    S_RECV_B = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SIZE    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CSUM    = 2'b11;

  localparam logic WR_SEL_A = 1'b0;
  localparam logic WR_SEL_B = 1'b1;

endpackage : mm_pkg
`default_nettype wire

// File: rtl/elem_assembler.sv
`default_nettype none
// ============================================================================
// Module   : elem_assembler
// Purpose  : Collects ELEM_BYTES received bytes (first byte = LSB) into one
//            element and flags the byte that completes it.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            clear_i      - discard any partially assembled element
//            valid_i      - byte_i carries a payload byte this cycle
//            byte_i       - payload byte
//            elem_o       - assembled element, valid while done_o is high
//            done_o       - this byte completes an element (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module elem_assembler #(
  parameter int ELEM_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    valid_i,
  input  logic [7:0]              byte_i,
  output logic [8*ELEM_BYTES-1:0] elem_o,
  output logic                    done_o
);

  localparam int EW = 8 * ELEM_BYTES;
  localparam int CW = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(ELEM_BYTES - 1);

  logic [EW-1:0] shift_q;
  logic [EW-1:0] shift_d;
  logic [CW-1:0] cnt_q;

  // New byte enters at the top and earlier bytes move down, so once all
  // ELEM_BYTES bytes have arrived the first one sits in the LSB position.
  // The completed element is taken straight from the next-state value so the
  // parent can register it on the same edge as the final byte.
  assign shift_d = EW'({byte_i, shift_q} >> 8);
  assign elem_o  = shift_d;
  assign done_o  = valid_i && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (valid_i) begin
      shift_q <= shift_d;
      cnt_q   <= done_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule : elem_assembler
`default_nettype wire

// File: rtl/matrix_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : matrix_frame_loader
// Purpose  : Parses a UART frame {N, A[N*N], B[N*N] [, checksum]} and writes
//            the elements row-major into the A/B operand memories, then holds
//            frame_done until the multiplier acknowledges.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            rx_valid, rx_data   - received byte strobe and data
//            wr_en/sel/addr/data - operand memory write port (registered)
//            mat_n               - N of the current / last accepted frame
//            frame_done, mm_ack  - frame hand-off to the multiplier
//            busy                - parser is inside a frame
//            err, err_code       - error pulse and sticky error cause
// Options  : FRAME_CHECKSUM_EN - expect a trailing XOR checksum byte
// Revision : 1.0 - initial release
// ============================================================================
module matrix_frame_loader
  import mm_pkg::*;
#(
  parameter int MAX_N       = 8,
  parameter int ELEM_BYTES  = 1,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int ADDR_W      = $clog2(MAX_N * MAX_N)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       wr_en,
  output logic                       wr_sel,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [8*ELEM_BYTES-1:0]    wr_data,
  output logic [$clog2(MAX_N+1)-1:0] mat_n,
  output logic                       frame_done,
  input  logic                       mm_ack,
  output logic                       busy,
  output logic                       err,
  output logic [1:0]                 err_code
);

  localparam int EW = 8 * ELEM_BYTES;
  localparam int NW = $clog2(MAX_N + 1);
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit TO_EN = (TIMEOUT_CYC > 0);
  // The counter holds the number of idle cycles already seen, so expiry is
  // flagged on the idle cycle whose count reaches TIMEOUT_CYC.
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t              state_q;
  logic [NW-1:0]       mat_n_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [NW-1:0]       row_q;
  logic [NW-1:0]       col_q;
  logic [TW-1:0]       to_q;
  logic                wr_en_q;
  logic                wr_sel_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [EW-1:0]       wr_data_q;
  logic                frame_done_q;
  logic                err_q;
  logic [1:0]          err_code_q;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          csum_q;
`endif

  logic          w_in_recv;
  logic          w_asm_valid;
  logic          w_elem_done;
  logic [EW-1:0] w_elem;
  logic          w_size_ok;
  logic          w_last_col;
  logic          w_last_elem;
  logic          w_expire;

  assign w_in_recv   = (state_q == S_RECV_A) || (state_q == S_RECV_B) ||
                       (state_q == S_CHECK);
  assign w_asm_valid = rx_valid && ((state_q == S_RECV_A) || (state_q == S_RECV_B));
  assign w_size_ok   = (rx_data != 8'd0) && (rx_data <= 8'(MAX_N));
  // Row/column counters find the last element of an N x N block without
  // needing N*N; idx_q alone supplies the row-major address.
  assign w_last_col  = ((col_q + NW'(1)) == mat_n_q);
  assign w_last_elem = w_last_col && ((row_q + NW'(1)) == mat_n_q);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign w_expire    = TO_EN && w_in_recv && !rx_valid && (to_q == TO_LAST);

  elem_assembler #(
    .ELEM_BYTES (ELEM_BYTES)
  ) u_elem_asm (
    .clk     (clk),
    .rst     (rst),
    .clear_i (state_q == S_IDLE),
    .valid_i (w_asm_valid),
    .byte_i  (rx_data),
    .elem_o  (w_elem),
    .done_o  (w_elem_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mat_n_q      <= '0;
      idx_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      to_q         <= '0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= WR_SEL_A;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
`ifdef FRAME_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= (rx_valid || !w_in_recv) ? '0 : to_q + TW'(1);

      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (w_size_ok) begin
              mat_n_q    <= rx_data[NW-1:0];
              err_code_q <= ERR_NONE;
              idx_q      <= '0;
              row_q      <= '0;
              col_q      <= '0;
`ifdef FRAME_CHECKSUM_EN
              csum_q     <= '0;
`endif
              state_q    <= S_RECV_A;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_SIZE;
            end
          end
        end

        S_RECV_A, S_RECV_B: begin
          if (rx_valid) begin
`ifdef FRAME_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            if (w_elem_done) begin
              wr_en_q   <= 1'b1;
              wr_sel_q  <= (state_q == S_RECV_B) ? WR_SEL_B : WR_SEL_A;
              wr_addr_q <= idx_q;
              wr_data_q <= w_elem;
              if (w_last_elem) begin
                idx_q <= '0;
                row_q <= '0;
                col_q <= '0;
                if (state_q == S_RECV_A) begin
                  state_q <= S_RECV_B;
                end else begin
`ifdef FRAME_CHECKSUM_EN
                  state_q <= S_CHECK;
`else
                  state_q <= S_DONE;
`endif
                end
              end else begin
                idx_q <= idx_q + ADDR_W'(1);
                if (w_last_col) begin
                  col_q <= '0;
                  row_q <= row_q + NW'(1);
                end else begin
                  col_q <= col_q + NW'(1);
                end
              end
            end
          end else if (w_expire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_IDLE;
          end
        end

`ifdef FRAME_CHECKSUM_EN
        S_CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              frame_done_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CSUM;
              state_q    <= S_IDLE;
            end
          end else if (w_expire) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= S_IDLE;
          end
        end
`endif

        S_DONE: begin
          // Without a checksum, DONE is entered on the final B write edge and
          // frame_done follows one cycle later. Bytes here are ignored.
          if (mm_ack) begin
            frame_done_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            frame_done_q <= 1'b1;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign mat_n      = mat_n_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule : matrix_frame_loader
`default_nettype wire

// File: tb/tb_matrix_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_frame_loader
// Purpose  : Directed self-checking bench for matrix_frame_loader. Two
//            instances run side by side: one with 1-byte elements, one with
//            2-byte elements, both with a 100-cycle inter-byte timeout.
//            Expected writes come from a frame-level model of the byte stream.
// Options  : FRAME_CHECKSUM_EN - frames carry a trailing XOR checksum
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_frame_loader;

  localparam int MAX_N  = 8;
  localparam int TO_CYC = 100;
  localparam int AW     = $clog2(MAX_N * MAX_N);
  localparam int NW     = $clog2(MAX_N + 1);

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic sel;
    int   addr;
    int   data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance A: 1-byte elements
  logic          a_rx_valid, a_mm_ack;
  logic [7:0]    a_rx_data;
  logic          a_wr_en, a_wr_sel, a_frame_done, a_busy, a_err;
  logic [AW-1:0] a_wr_addr;
  logic [7:0]    a_wr_data;
  logic [NW-1:0] a_mat_n;
  logic [1:0]    a_err_code;

  // instance B: 2-byte elements
  logic          b_rx_valid, b_mm_ack;
  logic [7:0]    b_rx_data;
  logic          b_wr_en, b_wr_sel, b_frame_done, b_busy, b_err;
  logic [AW-1:0] b_wr_addr;
  logic [15:0]   b_wr_data;
  logic [NW-1:0] b_mat_n;
  logic [1:0]    b_err_code;

  matrix_frame_loader #(.MAX_N(MAX_N), .ELEM_BYTES(1), .TIMEOUT_CYC(TO_CYC)) u_dut_a (
    .clk(clk), .rst(rst), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .mat_n(a_mat_n), .frame_done(a_frame_done), .mm_ack(a_mm_ack), .busy(a_busy),
    .err(a_err), .err_code(a_err_code)
  );

  matrix_frame_loader #(.MAX_N(MAX_N), .ELEM_BYTES(2), .TIMEOUT_CYC(TO_CYC)) u_dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .mat_n(b_mat_n), .frame_done(b_frame_done), .mm_ack(b_mm_ack), .busy(b_busy),
    .err(b_err), .err_code(b_err_code)
  );

  int  vectors     = 0;
  int  miscompares = 0;
  wr_t qa[$];
  wr_t qb[$];
  wr_t ea, eb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame-level model: every element whose bytes are all present in the
  // stream yields one write; the first N*N go to A, the rest to B.
  task automatic model_push(input int which, input int eb_n, input bq_t fb);
    int n;
    int d;
    wr_t w;
    n = int'(fb[0]);
    if (n < 1 || n > MAX_N) return;
    for (int e = 0; e < 2 * n * n; e++) begin
      if (1 + (e + 1) * eb_n > fb.size()) break;
      d = 0;
      for (int k = 0; k < eb_n; k++) d = d | (int'(fb[1 + e * eb_n + k]) << (8 * k));
      w.sel  = (e >= n * n);
      w.addr = w.sel ? e - n * n : e;
      w.data = d;
      if (which == 0) qa.push_back(w);
      else            qb.push_back(w);
    end
  endtask

  function automatic bq_t frame(input bq_t fb);
    bq_t r = fb;
`ifdef FRAME_CHECKSUM_EN
    byte unsigned x = 8'h00;
    for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_a(input bq_t fb);
    foreach (fb[i]) begin
      a_rx_data  = fb[i];
      a_rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    a_rx_valid = 1'b0;
  endtask

  task automatic drive_b(input bq_t fb);
    foreach (fb[i]) begin
      b_rx_data  = fb[i];
      b_rx_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    b_rx_valid = 1'b0;
  endtask

  // Wait for frame_done on A to be visible; without the checksum byte the
  // flag follows the final B write by one cycle.
  task automatic expect_done_a(input string name);
`ifndef FRAME_CHECKSUM_EN
    step(1);
`endif
    check(name, a_frame_done, 1);
  endtask

  task automatic ack_a(input string name);
    a_mm_ack = 1'b1;
    step(1);
    a_mm_ack = 1'b0;
    check({name, "_done_clr"}, a_frame_done, 0);
    check({name, "_busy_clr"}, a_busy, 0);
    check({name, "_all_writes"}, qa.size(), 0);
  endtask

  task automatic check_reset_a(input string name);
    check({name, "_wr_en"}, a_wr_en, 0);
    check({name, "_wr_sel"}, a_wr_sel, 0);
    check({name, "_wr_addr"}, a_wr_addr, 0);
    check({name, "_wr_data"}, a_wr_data, 0);
    check({name, "_mat_n"}, a_mat_n, 0);
    check({name, "_frame_done"}, a_frame_done, 0);
    check({name, "_busy"}, a_busy, 0);
    check({name, "_err"}, a_err, 0);
    check({name, "_err_code"}, a_err_code, 0);
  endtask

  // Single compare process: each write strobe must match the next expected
  // write of that instance, and any write with nothing expected is an error.
  always @(negedge clk) begin
    if (a_wr_en === 1'b1) begin
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL a_unexpected_write: got sel %0d addr %0d data 0x%0h, expected no write",
                 a_wr_sel, a_wr_addr, a_wr_data);
      end else begin
        ea = qa.pop_front();
        check("a_wr_sel", a_wr_sel, ea.sel);
        check("a_wr_addr", a_wr_addr, ea.addr);
        check("a_wr_data", a_wr_data, ea.data);
      end
    end
    if (b_wr_en === 1'b1) begin
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL b_unexpected_write: got sel %0d addr %0d data 0x%0h, expected no write",
                 b_wr_sel, b_wr_addr, b_wr_data);
      end else begin
        eb = qb.pop_front();
        check("b_wr_sel", b_wr_sel, eb.sel);
        check("b_wr_addr", b_wr_addr, eb.addr);
        check("b_wr_data", b_wr_data, eb.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time %0t, expected finish before 200000", $time);
    $fatal(1);
  end

  initial begin
    bq_t f;
    bq_t p;
    int  seen;

    a_rx_valid = 1'b0; a_rx_data = 8'h00; a_mm_ack = 1'b0;
    b_rx_valid = 1'b0; b_rx_data = 8'h00; b_mm_ack = 1'b0;

    // ---------------- reset state ----------------
    rst = 1'b1;
    step(3);
    check_reset_a("rst0");
    check("rst0_b_busy", b_busy, 0);
    rst = 1'b0;
    step(1);

    // ---------------- N=3, 1-byte elements ----------------
    f = '{8'h03,
          8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04, 8'h04, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08, 8'h07, 8'h08, 8'h08, 8'h07, 8'h08};
    f = frame(f);
    model_push(0, 1, f);
    check("model_a_count", qa.size(), 18);
    check("model_a_A4_data", qa[4].data, 32'h03);
    check("model_a_B0_sel", qa[9].sel, 1);
    check("model_a_B0_addr", qa[9].addr, 0);
    check("model_a_B8_data", qa[17].data, 32'h08);
    drive_a(f);
    expect_done_a("n3_done");
    check("n3_mat_n", a_mat_n, 3);
    check("n3_busy", a_busy, 1);
    check("n3_err_code", a_err_code, 0);
    // bytes during DONE are dropped without writes or errors
    drive_a('{8'h11, 8'h22, 8'h03});
    check("done_drop_err", a_err, 0);
    check("done_drop_code", a_err_code, 0);
    step(2);
    check("done_hold", a_frame_done, 1);
    ack_a("n3");

    // ---------------- bad size bytes ----------------
    drive_a('{8'h00});
    check("size00_err", a_err, 1);
    check("size00_code", a_err_code, 1);
    check("size00_busy", a_busy, 0);
    step(1);
    check("size00_pulse", a_err, 0);
    check("size00_sticky", a_err_code, 1);
    drive_a('{8'h09});
    check("size09_err", a_err, 1);
    check("size09_code", a_err_code, 1);
    check("size09_busy", a_busy, 0);
    check("size09_mat_n", a_mat_n, 3);
    step(1);
    check("size09_pulse", a_err, 0);

    // ---------------- 2-byte elements, N=1 ----------------
    f = '{8'h01, 8'h34, 8'h12, 8'hCD, 8'hAB};
    f = frame(f);
    model_push(1, 2, f);
    check("model_b_A0", qb[0].data, 32'h1234);
    check("model_b_B0", qb[1].data, 32'hABCD);
    drive_b(f);
`ifndef FRAME_CHECKSUM_EN
    step(1);
`endif
    check("eb2_done", b_frame_done, 1);
    check("eb2_mat_n", b_mat_n, 1);
    b_mm_ack = 1'b1;
    step(1);
    b_mm_ack = 1'b0;
    check("eb2_done_clr", b_frame_done, 0);
    check("eb2_all_writes", qb.size(), 0);

    // ---------------- inter-byte timeout ----------------
    p = '{8'h03, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    model_push(0, 1, p);
    drive_a(p);
    check("to_hdr_clears_code", a_err_code, 0);
    check("to_busy", a_busy, 1);
    seen = -1;
    for (int k = 1; k <= 130; k++) begin
      step(1);
      if (a_err === 1'b1 && seen < 0) seen = k;
    end
    check("to_err_cycle", seen, TO_CYC);
    check("to_code", a_err_code, 2);
    check("to_busy_clr", a_busy, 0);
    check("to_no_done", a_frame_done, 0);
    check("to_partial_writes", qa.size(), 0);
    f = '{8'h02, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    f = frame(f);
    model_push(0, 1, f);
    drive_a(f);
    expect_done_a("to_next_done");
    check("to_next_mat_n", a_mat_n, 2);
    ack_a("to_next");

    // ---------------- reset mid-frame ----------------
    p = '{8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
    model_push(0, 1, p);
    drive_a(p);
    check("mid_busy", a_busy, 1);
    rst = 1'b1;
    step(1);
    check_reset_a("mid_rst");
    rst = 1'b0;
    check("mid_partial_writes", qa.size(), 0);
    f = '{8'h03,
          8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29,
          8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    f = frame(f);
    model_push(0, 1, f);
    drive_a(f);
    expect_done_a("post_rst_done");
    check("post_rst_mat_n", a_mat_n, 3);
    ack_a("post_rst");

`ifdef FRAME_CHECKSUM_EN
    // ---------------- checksum ----------------
    f = frame('{8'h01, 8'h0F, 8'hF0});
    check("model_csum", f[3], 32'hFF);
    f = '{8'h01, 8'h0F, 8'hF0, 8'hFF};
    model_push(0, 1, f);
    drive_a(f);
    check("csum_ok_done", a_frame_done, 1);
    check("csum_ok_err", a_err, 0);
    drive_a('{8'h05, 8'h06});
    check("csum_drop_done", a_frame_done, 1);
    ack_a("csum_ok");
    f = '{8'h01, 8'h0F, 8'hF0, 8'hFE};
    model_push(0, 1, f);
    drive_a(f);
    check("csum_bad_err", a_err, 1);
    check("csum_bad_code", a_err_code, 3);
    check("csum_bad_busy", a_busy, 0);
    check("csum_bad_done", a_frame_done, 0);
    step(3);
    check("csum_bad_done_later", a_frame_done, 0);
    check("csum_bad_writes", qa.size(), 0);
`endif

    step(3);
    check("final_a_queue", qa.size(), 0);
    check("final_b_queue", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_matrix_frame_loader
`default_nettype wire

// File: doc/matrix_frame_loader.md
# matrix_frame_loader

Parametrised receive-side frame parser for the UART matrix-multiplication datapath. Consumes bytes from the UART receiver and decodes a frame of one size byte N, N×N elements of matrix A and N×N elements of matrix B. Writes the elements row-major into the A/B operand memories and hands the completed frame to the multiplier. Generalises the original fixed-size loader: variable N up to MAX_N, multi-byte elements, inter-byte timeout and error reporting.

## Interface
- MAX_N, 8, largest accepted matrix dimension
- ELEM_BYTES, 1, bytes per element, little-endian; element width EW = 8·ELEM_BYTES
- TIMEOUT_CYC, 2_000_000, idle clocks between bytes inside a frame before abort; 0 disables the timeout
- ADDR_W, $clog2(MAX_N·MAX_N), derived operand-memory address width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- wr_en  out  1  operand memory write strobe
- wr_sel  out  1  0 = matrix A, 1 = matrix B
- wr_addr  out  ADDR_W  row·N + col
- wr_data  out  EW  assembled element
- mat_n  out  4..8 ($clog2(MAX_N+1))  latched N of the current/last frame
- frame_done  out  1  frame complete, held until mm_ack
- mm_ack  in  1  multiplier has taken the frame
- busy  out  1  state ≠ IDLE
- err  out  1  one-cycle error pulse
- err_code  out  2  01 bad size, 10 timeout, 11 checksum; sticky until next accepted header

## Operation
- States: IDLE, RECV_A, RECV_B, CHECK (only with checksum), DONE.
- IDLE: next rx byte = N. 1 ≤ N ≤ MAX_N → latch mat_n, clear err_code, clear counters, go to RECV_A. Otherwise pulse err, err_code=01, stay IDLE.
- RECV_A/RECV_B: bytes shift into an element assembler, first byte = LSB. The last byte of an element produces one write. The element index runs 0..N²−1. After write N²−1 the block moves RECV_A→RECV_B, then RECV_B→CHECK or DONE.
- DONE: frame_done=1. Bytes received here are dropped, with no write and no error. mm_ack → IDLE. mm_ack outside DONE is ignored.
- Timeout: the counter resets on every rx_valid and counts while in RECV_A/RECV_B/CHECK. Reaching TIMEOUT_CYC → err pulse, err_code=10, IDLE. Partially written memory is not cleared.
- Address arithmetic: an incrementing index, no multiplier. Wrap to 0 on the A→B transition.

## Timing
- Reset values: wr_en=0, wr_sel=0, wr_addr=0, wr_data=0, mat_n=0, frame_done=0, busy=0, err=0, err_code=00. State is IDLE and all counters are 0.
- wr_en is registered and asserts for exactly one cycle, the cycle after rx_valid of the element's last byte. wr_sel, wr_addr and wr_data are valid in that same cycle.
- frame_done rises the cycle after the final B write, or with checksum, the cycle after the checksum byte. It falls the cycle after mm_ack is sampled high.
- rx_valid and a timeout expiry in the same cycle: the byte wins.
- err is a one-cycle pulse registered the cycle after the offending byte or expiry.
- rst mid-frame aborts immediately to reset values. The frame is lost.
- Back-to-back rx_valid on consecutive cycles must be accepted without loss.

## Configuration
- FRAME_CHECKSUM_EN defined: a trailing byte follows B and must equal the XOR of every byte after the size byte. The block checks it in CHECK.
  - Match → DONE.
  - Mismatch → err pulse, err_code=11, IDLE, and frame_done is never raised.
  - The checksum byte is subject to the timeout.
- FRAME_CHECKSUM_EN undefined: no CHECK state and no XOR register. DONE follows the last B write, and code 11 is never produced.

## Structure
- Shared package mm_pkg holds:
  - the state enum (S_IDLE, S_RECV_A, S_RECV_B, S_CHECK, S_DONE)
  - the err_code constants ERR_NONE, ERR_SIZE, ERR_TIMEOUT, ERR_CSUM
  - the WR_SEL_A/WR_SEL_B constants
- One sub-module, elem_assembler, does the byte-to-element shift, byte count and element-complete strobe, parametrised by ELEM_BYTES.

## Test plan
- N=3, ELEM_BYTES=1, A bytes 01 02 03 04 03 04 04 03 04, B bytes 05 06 07 08 07 08 08 07 08:
  - 9 A writes at addr 0..8 and 9 B writes with matching data.
  - frame_done is high 1 cycle after the last write and clears after mm_ack.
- Size byte 00 and size byte 09 (MAX_N=8): err pulse, err_code=01, no writes, busy stays 0.
- ELEM_BYTES=2, N=1, bytes 01 34 12 CD AB → A[0]=0x1234 and B[0]=0xABCD.
- TIMEOUT_CYC=100: stop after 4 A bytes → err at idle cycle 100, err_code=10, IDLE. A new valid frame then loads correctly.
- rst asserted after 5 bytes of a frame → all outputs at reset values next cycle. A following full frame loads correctly.
- FRAME_CHECKSUM_EN, N=1, bytes 01 0F F0:
  - checksum FF → frame_done.
  - checksum FE → err_code=11, no frame_done.
  - Bytes sent during DONE produce no writes.
